// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the three-port memory arbiter: FSM states, requester indices
// and small helpers for round-robin pointer handling.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] PORT_I = 2'd0;
  localparam logic [1:0] PORT_D = 2'd1;
  localparam logic [1:0] PORT_X = 2'd2;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_X) ? PORT_I : p + 2'd1;
  endfunction

  function automatic logic [1:0] gnt_to_port(input logic [2:0] g);
    if (g[PORT_X])      return PORT_X;
    else if (g[PORT_D]) return PORT_D;
    else                return PORT_I;
  endfunction

endpackage

// File: rtl/rr_picker3.sv
// Combinational 3-way round-robin picker: search starts at ptr and wraps I -> D -> X -> I;
// returns a one-hot grant (all zero when nothing requests).
module rr_picker3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I/D/X requesters onto one single-port SRAM with round-robin fairness.
// One access takes MEM_LAT+2 cycles (IDLE sample, MEM_LAT ACCESS, one DONE pulse).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              x_req,
  input  logic              i_write,
  input  logic              d_write,
  input  logic              x_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              i_done,
  output logic              d_done,
  output logic              x_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  logic [1:0]        rr_ptr;
  logic [1:0]        win;
  logic              wr_q;
  logic [3:0]        wait_cnt;
  logic              last_cyc;
  logic [2:0]        req_vec;
  logic [2:0]        gnt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec  = {x_req, d_req, i_req};
  assign last_cyc = (wait_cnt == 4'(MEM_LAT - 1));

  rr_picker3 u_picker (
    .req (req_vec),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    sel_write = i_write;
    sel_addr  = i_addr;
    sel_wdata = i_wdata;
    if (gnt[PORT_D]) begin
      sel_write = d_write;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else if (gnt[PORT_X]) begin
      sel_write = x_write;
      sel_addr  = x_addr;
      sel_wdata = x_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_vec) state_nxt = ACCESS;
      ACCESS:  if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= PORT_I;
      win       <= PORT_I;
      wr_q      <= 1'b0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (|req_vec) begin
            win       <= gnt_to_port(gnt);
            wr_q      <= sel_write;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          wait_cnt <= last_cyc ? 4'd0 : wait_cnt + 4'd1;
          if (last_cyc && !wr_q) rdata <= mem_rdata;
        end
        DONE:    rr_ptr <= next_port(win);
        default: ;
      endcase
    end
  end

  // Strobes are decoded from registered state, so a reset edge clears them immediately.
  assign busy       = (state != IDLE);
  assign mem_enable = (state == ACCESS);
  assign mem_read   = mem_enable && !wr_q;
  assign mem_write  = mem_enable && wr_q;
  assign i_done     = (state == DONE) && (win == PORT_I);
  assign d_done     = (state == DONE) && (win == PORT_D);
  assign x_done     = (state == DONE) && (win == PORT_X);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4) share stimulus; one is observed at a time
// and completions are checked against a queue of expected transactions.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic        i_done, d_done, x_done, busy, mem_enable, mem_read, mem_write;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, rdata;
  } obs_t;

  typedef struct {
    logic [1:0]  port;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_req = 0, d_req = 0, x_req = 0, i_write = 0, d_write = 0, x_write = 0;
  logic [11:0] i_addr = 0, d_addr = 0, x_addr = 0;
  logic [31:0] i_wdata = 0, d_wdata = 0, x_wdata = 0;
  logic [31:0] rd1, rd3, rd4;
  logic [31:0] mem [4096];
  obs_t o1, o3, o4, o;
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign rd1 = mem[o1.mem_addr];
  assign rd3 = mem[o3.mem_addr];
  assign rd4 = mem[o4.mem_addr];

  always_comb begin
    o = o1;
    if (sel == 1) o = o3;
    else if (sel == 2) o = o4;
  end

  always @(posedge clk) if (o.mem_write) mem[o.mem_addr] <= o.mem_wdata;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .x_req(x_req),
    .i_write(i_write), .d_write(d_write), .x_write(x_write),
    .i_addr(i_addr), .d_addr(d_addr), .x_addr(x_addr),
    .i_wdata(i_wdata), .d_wdata(d_wdata), .x_wdata(x_wdata),
    .i_done(o1.i_done), .d_done(o1.d_done), .x_done(o1.x_done), .rdata(o1.rdata),
    .busy(o1.busy), .mem_enable(o1.mem_enable), .mem_read(o1.mem_read), .mem_write(o1.mem_write),
    .mem_addr(o1.mem_addr), .mem_wdata(o1.mem_wdata), .mem_rdata(rd1));

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .x_req(x_req),
    .i_write(i_write), .d_write(d_write), .x_write(x_write),
    .i_addr(i_addr), .d_addr(d_addr), .x_addr(x_addr),
    .i_wdata(i_wdata), .d_wdata(d_wdata), .x_wdata(x_wdata),
    .i_done(o3.i_done), .d_done(o3.d_done), .x_done(o3.x_done), .rdata(o3.rdata),
    .busy(o3.busy), .mem_enable(o3.mem_enable), .mem_read(o3.mem_read), .mem_write(o3.mem_write),
    .mem_addr(o3.mem_addr), .mem_wdata(o3.mem_wdata), .mem_rdata(rd3));

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .x_req(x_req),
    .i_write(i_write), .d_write(d_write), .x_write(x_write),
    .i_addr(i_addr), .d_addr(d_addr), .x_addr(x_addr),
    .i_wdata(i_wdata), .d_wdata(d_wdata), .x_wdata(x_wdata),
    .i_done(o4.i_done), .d_done(o4.d_done), .x_done(o4.x_done), .rdata(o4.rdata),
    .busy(o4.busy), .mem_enable(o4.mem_enable), .mem_read(o4.mem_read), .mem_write(o4.mem_write),
    .mem_addr(o4.mem_addr), .mem_wdata(o4.mem_wdata), .mem_rdata(rd4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    i_req = 0; d_req = 0; x_req = 0;
    i_write = 0; d_write = 0; x_write = 0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Advances until any done of the observed instance is high or the budget runs out (dv stays 0).
  task automatic wait_done(input int max_cyc, output logic [2:0] dv, output int n);
    dv = 3'b000;
    n  = 0;
    while (n < max_cyc) begin
      tick();
      n++;
      dv = {o.x_done, o.d_done, o.i_done};
      if (dv != 3'b000) break;
    end
  endtask

  task automatic test_reset();
    logic [2:0] dv;
    int n;
    exp_t e;
    sel = 0;
    i_req = 1; d_req = 1; x_req = 1;
    i_addr = 12'h010; d_addr = 12'h020; x_addr = 12'h030;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({o.i_done, o.d_done, o.x_done, o.mem_enable, o.busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b required 00000", c, {o.i_done, o.d_done, o.x_done, o.mem_enable, o.busy});
      end
      checks++;
      if ({o.mem_addr, o.mem_wdata, o.rdata} !== '0) begin
        errors++;
        $display("FAIL reset_regs cycle %0d: addr %h wdata %h rdata %h required 0", c, o.mem_addr, o.mem_wdata, o.rdata);
      end
    end
    rst = 1'b1;
    sb.push_back('{port: PORT_I, wr: 1'b0, rdata: mem[12'h010]});
    wait_done(10, dv, n);
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port)) begin
      errors++;
      $display("FAIL reset_first_grant: got done %b required %b", dv, 3'b001 << e.port);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_single_read();
    logic [2:0] dv;
    exp_t e;
    sel = 0;
    apply_reset();
    mem[12'h01A] = 32'hDEADBEEF;
    d_req = 1; d_write = 0; d_addr = 12'h01A;
    sb.push_back('{port: PORT_D, wr: 1'b0, rdata: 32'hDEADBEEF});
    tick();
    checks++;
    if ({o.mem_enable, o.mem_read, o.mem_write, o.mem_addr} !== {3'b110, 12'h01A}) begin
      errors++;
      $display("FAIL read_strobe: en/rd/wr/addr %b%b%b %h required 110 01a", o.mem_enable, o.mem_read, o.mem_write, o.mem_addr);
    end
    tick();
    dv = {o.x_done, o.d_done, o.i_done};
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port) || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL read_done: done %b rdata %h required %b %h", dv, o.rdata, 3'b001 << e.port, e.rdata);
    end
    checks++;
    if (o.mem_read !== 1'b0 || o.mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL read_strobe_width: mem_read %b mem_enable %b in done cycle, required 0 0", o.mem_read, o.mem_enable);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_single_write();
    exp_t e;
    logic [2:0] dv;
    sel = 1;
    apply_reset();
    x_req = 1; x_write = 1; x_addr = 12'hFFF; x_wdata = 32'h12345678;
    sb.push_back('{port: PORT_X, wr: 1'b1, rdata: 32'h0});
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({o.mem_enable, o.mem_write, o.mem_read, o.mem_addr, o.mem_wdata} !== {3'b110, 12'hFFF, 32'h12345678} ||
          {o.i_done, o.d_done, o.x_done} !== 3'b000) begin
        errors++;
        $display("FAIL write_access cycle %0d: en/wr/rd %b%b%b addr %h wdata %h dones %b required 110 fff 12345678 000",
                 c, o.mem_enable, o.mem_write, o.mem_read, o.mem_addr, o.mem_wdata, {o.i_done, o.d_done, o.x_done});
      end
    end
    tick();
    dv = {o.x_done, o.d_done, o.i_done};
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port) || o.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL write_done: done %b mem_write %b required %b 0", dv, o.mem_write, 3'b001 << e.port);
    end
    checks++;
    if (o.rdata !== 32'h0 || mem[12'hFFF] !== 32'h12345678) begin
      errors++;
      $display("FAIL write_effect: rdata %h mem[fff] %h required 00000000 12345678", o.rdata, mem[12'hFFF]);
    end
    clear_reqs();
    tick();
    checks++;
    if ({o.i_done, o.d_done, o.x_done} !== 3'b000) begin
      errors++;
      $display("FAIL write_single_pulse: dones %b after done cycle, required 000", {o.i_done, o.d_done, o.x_done});
    end
  endtask

  task automatic test_contention();
    logic [2:0] dv;
    int n;
    int cnt [3];
    exp_t e;
    sel = 0;
    apply_reset();
    cnt = '{0, 0, 0};
    i_req = 1; d_req = 1; x_req = 1;
    i_addr = 12'h100; d_addr = 12'h200; x_addr = 12'h300;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] p;
      p = 2'(k % 3);
      sb.push_back('{port: p, wr: 1'b0, rdata: mem[(p == PORT_I) ? 12'h100 : (p == PORT_D) ? 12'h200 : 12'h300]});
    end
    for (int k = 0; k < 12; k++) begin
      wait_done(10, dv, n);
      e = sb.pop_front();
      checks++;
      if ($countones(dv) != 1 || dv !== (3'b001 << e.port) || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL contention_order txn %0d: done %b rdata %h required %b %h", k, dv, o.rdata, 3'b001 << e.port, e.rdata);
      end
      checks++;
      if (n != ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("FAIL contention_spacing txn %0d: %0d cycles required %0d", k, n, (k == 0) ? 2 : 3);
      end
      for (int b = 0; b < 3; b++) if (dv[b]) cnt[b]++;
    end
    checks++;
    if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 4) begin
      errors++;
      $display("FAIL contention_counts: I %0d D %0d X %0d required 4 4 4", cnt[0], cnt[1], cnt[2]);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_early_drop();
    logic [2:0] dv;
    int n;
    int extra;
    exp_t e;
    sel = 0;
    apply_reset();
    d_req = 1; d_write = 0; d_addr = 12'h055;
    sb.push_back('{port: PORT_D, wr: 1'b0, rdata: mem[12'h055]});
    tick();
    d_req = 0;
    wait_done(10, dv, n);
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port) || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL early_drop_done: done %b rdata %h required %b %h", dv, o.rdata, 3'b001 << e.port, e.rdata);
    end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o.busy || o.i_done || o.d_done || o.x_done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL early_drop_no_rerun: %0d busy/done cycles after completion, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] dv;
    int n;
    int extra;
    exp_t e;
    sel = 2;
    apply_reset();
    i_req = 1; i_addr = 12'h040;
    sb.push_back('{port: PORT_I, wr: 1'b0, rdata: mem[12'h040]});
    wait_done(12, dv, n);
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port) || n != 5) begin
      errors++;
      $display("FAIL lat4_read: done %b after %0d cycles required %b after 5", dv, n, 3'b001 << e.port);
    end
    clear_reqs();
    tick();
    d_req = 1; d_addr = 12'h050;
    tick();
    tick();
    checks++;
    if (o.mem_enable !== 1'b1 || o.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_access: mem_enable %b mem_read %b required 1 1", o.mem_enable, o.mem_read);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({o.mem_enable, o.mem_read, o.busy, o.i_done, o.d_done, o.x_done} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_abort: en/rd/busy/dones %b required 000000", {o.mem_enable, o.mem_read, o.busy, o.i_done, o.d_done, o.x_done});
    end
    rst = 1'b1;
    d_req = 0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o.i_done || o.d_done || o.x_done || o.busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL midreset_no_done: %0d busy/done cycles after abort, required 0", extra);
    end
    i_req = 1; d_req = 1;
    sb.push_back('{port: PORT_I, wr: 1'b0, rdata: mem[12'h040]});
    wait_done(12, dv, n);
    e = sb.pop_front();
    checks++;
    if (dv !== (3'b001 << e.port) || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL midreset_ptr: done %b rdata %h required %b %h", dv, o.rdata, 3'b001 << e.port, e.rdata);
    end
    clear_reqs();
    tick();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'hA5000000 | 32'(a * 7);
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_early_drop();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 32-bit memory between three requesters: instruction fetch (I), data load/store (D) and an external DMA/debug port (X).
- Sits between the core's IM/DM strobes and a unified SRAM. It serialises accesses, inserts configurable memory wait states and returns a one-cycle done pulse with read data to the granted requester.
- Arbitration is round-robin, so none of the three ports can starve.

Parameters:
- ADDR_W, 12, word-address width of every port and of the memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the memory needs with enable held before rdata is valid or a write commits (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- i_req, d_req, x_req  in  1 each  access request, one per requester.
- i_write, d_write, x_write  in  1 each  1 = write, 0 = read.
- i_addr, d_addr, x_addr  in  ADDR_W each  word address.
- i_wdata, d_wdata, x_wdata  in  DATA_W each  write data.
- i_done, d_done, x_done  out  1 each  one-cycle completion pulse.
- rdata  out  DATA_W  read data, shared by all ports; valid only in a done cycle.
- busy  out  1  high in any state other than IDLE.
- mem_enable  out  1  memory enable.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0 at a rising edge) forces:
  - state = IDLE; rr pointer = I;
  - all done outputs, busy, mem_enable, mem_read and mem_write = 0;
  - mem_addr, mem_wdata and rdata = 0;
  - wait counter = 0.
- Reset asserted mid-transaction aborts the access: no done pulse, and memory strobes drop in the next cycle.
- State machine:
  - IDLE -> ACCESS when any req is high at a clock edge.
  - ACCESS -> DONE after MEM_LAT cycles.
  - DONE -> IDLE unconditionally.
- Arbitration, evaluated only in IDLE:
  - Search order starts at the rr pointer and runs I -> D -> X -> I.
  - The first requester with req=1 wins.
  - The winner's write, addr and wdata are latched into mem_write/mem_read/mem_addr/mem_wdata at the same edge.
  - In DONE, the rr pointer moves to the port after the winner.
- ACCESS:
  - mem_enable=1 and exactly one of mem_read/mem_write is high.
  - Address and data stay stable for all MEM_LAT cycles.
  - The wait counter counts 0..MEM_LAT-1.
  - On the last ACCESS cycle mem_rdata is captured into rdata; for writes rdata is unchanged.
- DONE:
  - The winner's done=1 for exactly one cycle.
  - mem_enable, mem_read and mem_write = 0.
  - rdata holds the captured value.
- Latency: req sampled high at edge t -> done high in cycle t+MEM_LAT+1. One transaction occupies MEM_LAT+2 cycles including the IDLE sample cycle. With continuous requests, back-to-back throughput is one access per MEM_LAT+2 cycles.
- Requester contract: hold req/write/addr/wdata stable until its done pulse, then drop req or present the next request.
- Dropping req before done: the latched transaction still completes and done still pulses.
- Simultaneous requests: only the rr-ordered winner proceeds; losers wait with req held.
- No two done outputs are ever high in the same cycle.
- A requester that keeps req high after done competes again in the next IDLE. Because the rr pointer has moved past it, it is serviced again only after the other pending requesters.
- busy = (state != IDLE).

Decomposition:
- Shared package: state encoding constants (IDLE, ACCESS, DONE) and port-index constants (PORT_I=0, PORT_D=1, PORT_X=2).
- The package is reused by the core controller and the testbench.
- One natural sub-module, rr_picker3: combinational round-robin picker taking 3 req bits plus a 2-bit pointer and returning a one-hot grant. Everything else is flat.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req=1 -> every done=0, mem_enable=0, busy=0. First grant after release goes to I.
- Single read, MEM_LAT=1: d_req=1, d_write=0, d_addr=0x01A, memory returns 0xDEADBEEF -> mem_read=1 with mem_addr=0x01A for exactly 1 cycle; d_done=1 and rdata=0xDEADBEEF two cycles after the request edge.
- Single write, MEM_LAT=3: x_req=1, x_write=1, x_addr=0xFFF, x_wdata=0x12345678 -> mem_write=1 for 3 consecutive cycles with stable addr/data; x_done pulses once on the 4th cycle after the request edge; i_done=d_done=0 throughout.
- Contention: i_req, d_req, x_req all held high for 12 transactions -> grant order I,D,X,I,D,X...; exactly one done per transaction; each port receives 4 dones.
- Early drop: d_req pulsed for only 1 cycle -> the access still runs and d_done pulses once; no second access is started for D.
- Reset mid-ACCESS with MEM_LAT=4: rst=0 on the 2nd ACCESS cycle -> no done pulse; mem_enable=0 the next cycle; state returns to IDLE and the rr pointer returns to I.
